wh_out_arb: RTL and testbench

WH_OUT_ARB -- requirements
Module: wh_out_arb

---
 rtl/wh_out_arb_if.sv | 42 ++++
 rtl/wh_out_arb.sv | 133 +++++++++++++
 tb/tb_wh_out_arb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wh_out_arb_if.sv
// Handshake bundle between the input buffers / downstream link and one
// wormhole output-port arbiter.
interface wh_out_arb_if;
  // Per-input destination port of the head-of-queue flit
  logic [2:0] port_0;
  logic [2:0] port_1;
  logic [2:0] port_2;
  logic [2:0] port_3;
  logic [2:0] port_4;
  // Per-input valid flit indication
  logic       req_0;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       req_4;
  // Bit i marks input i's current flit as the packet tail
  logic [4:0] tail;
  // Downstream freed one buffer slot this cycle
  logic       credit_ret;
  // Arbiter results
  logic [4:0] grt;
  logic [4:0] sel;
  logic       busy;
  logic [2:0] credits;
  logic       cred_err;

  // Requesters and downstream link side
  modport master (
    output port_0, port_1, port_2, port_3, port_4,
    output req_0, req_1, req_2, req_3, req_4,
    output tail, credit_ret,
    input  grt, sel, busy, credits, cred_err
  );

  // Arbiter side
  modport slave (
    input  port_0, port_1, port_2, port_3, port_4,
    input  req_0, req_1, req_2, req_3, req_4,
    input  tail, credit_ret,
    output grt, sel, busy, credits, cred_err
  );
endinterface

// File: rtl/wh_out_arb.sv
// Wormhole output-port arbiter: round-robin selection among five inputs
// targeting this output, packet-granular locking until the owner's tail
// transfers, and credit-based flow control toward the downstream buffer.
module wh_out_arb #(
  parameter int PORTID  = 0,
  parameter int CREDITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  wh_out_arb_if.slave  arb
);

  localparam logic [2:0] PID      = 3'(PORTID);
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0] state_r;
  logic [4:0] sel_r;
  logic [2:0] owner_r;
  logic [2:0] ptr_r;
  logic [2:0] credits_r;
  logic       cred_err_r;

  logic [4:0] elig;
  logic [4:0] req_v;
  logic       any_elig;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       owner_tail;
  logic       fire;

  // First eligible index strictly after ptr, wrapping 4 -> 0; ptr itself
  // is visited last so the previous owner gets lowest priority.
  function automatic logic [2:0] rr_pick(input logic [4:0] e, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = 3'd0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 5; k++) begin
      idx = (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
      if (!found && e[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [4:0] to_onehot(input logic [2:0] idx);
    logic [4:0] oh;
    oh = 5'd0;
    for (int k = 0; k < 5; k++) begin
      if (idx == 3'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

  assign req_v = {arb.req_4, arb.req_3, arb.req_2, arb.req_1, arb.req_0};

  // Eligibility: valid flit whose destination is this output port
  always_comb begin
    elig    = 5'd0;
    elig[0] = req_v[0] && (arb.port_0 == PID);
    elig[1] = req_v[1] && (arb.port_1 == PID);
    elig[2] = req_v[2] && (arb.port_2 == PID);
    elig[3] = req_v[3] && (arb.port_3 == PID);
    elig[4] = req_v[4] && (arb.port_4 == PID);
  end

  assign any_elig   = |elig;
  assign win_idx    = rr_pick(elig, ptr_r);
  assign owner_req  = |(elig & sel_r);
  assign owner_tail = |(arb.tail & sel_r);
  // A flit moves only while locked, the owner presents one, and a slot is free
  assign fire       = (state_r == S_LOCK) && owner_req && (credits_r != 3'd0);

  assign arb.grt      = fire ? sel_r : 5'd0;
  assign arb.sel      = sel_r;
  assign arb.busy     = (state_r == S_LOCK);
  assign arb.credits  = credits_r;
  assign arb.cred_err = cred_err_r;

  // Arbitrate in IDLE, hold the owner through the packet, release on tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      sel_r   <= 5'd0;
      owner_r <= 3'd0;
      ptr_r   <= 3'd4;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_elig) begin
            state_r <= S_LOCK;
            owner_r <= win_idx;
            sel_r   <= to_onehot(win_idx);
          end
        end
        S_LOCK: begin
          if (fire && owner_tail) begin
            state_r <= S_IDLE;
            sel_r   <= 5'd0;
            ptr_r   <= owner_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
          sel_r   <= 5'd0;
        end
      endcase
    end
  end

  // Credit counter: fire consumes, credit_ret refills, overflow is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_r  <= CRED_MAX;
      cred_err_r <= 1'b0;
    end else begin
      if (fire && !arb.credit_ret) begin
        credits_r <= credits_r - 3'd1;
      end else if (arb.credit_ret && !fire) begin
        if (credits_r >= CRED_MAX) cred_err_r <= 1'b1;
        else                       credits_r  <= credits_r + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_wh_out_arb.sv
// Bench for wh_out_arb: one instance with CREDITS=4, one with CREDITS=2,
// both fed the same stimulus; each vector names which instance it checks.
module tb_wh_out_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wh_out_arb_if bus ();
  wh_out_arb_if bus2 ();

  wh_out_arb #(.PORTID(0), .CREDITS(4)) dut  (.clk(clk), .rst(rst), .arb(bus));
  wh_out_arb #(.PORTID(0), .CREDITS(2)) dut2 (.clk(clk), .rst(rst), .arb(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  req;
    logic [14:0] ports;
    logic [4:0]  tail;
    logic        cr;
    logic        d2;
    logic [4:0]  grt;
    logic [4:0]  sel;
    logic        busy;
    logic [2:0]  cred;
    logic        err;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[18];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;

  function automatic vec_t mk(input logic [4:0] req, input logic [14:0] ports,
                              input logic [4:0] tail, input logic cr, input logic d2,
                              input logic [4:0] grt, input logic [4:0] sel,
                              input logic busy, input logic [2:0] cred, input logic err);
    vec_t v;
    v.req = req; v.ports = ports; v.tail = tail; v.cr = cr; v.d2 = d2;
    v.grt = grt; v.sel = sel; v.busy = busy; v.cred = cred; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0h want %0h", nm, vec_n, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] req, input logic [14:0] ports,
                       input logic [4:0] tail, input logic cr);
    bus.req_0 = req[0]; bus.req_1 = req[1]; bus.req_2 = req[2];
    bus.req_3 = req[3]; bus.req_4 = req[4];
    bus.port_0 = ports[2:0];  bus.port_1 = ports[5:3];  bus.port_2 = ports[8:6];
    bus.port_3 = ports[11:9]; bus.port_4 = ports[14:12];
    bus.tail = tail; bus.credit_ret = cr;
    bus2.req_0 = req[0]; bus2.req_1 = req[1]; bus2.req_2 = req[2];
    bus2.req_3 = req[3]; bus2.req_4 = req[4];
    bus2.port_0 = ports[2:0];  bus2.port_1 = ports[5:3];  bus2.port_2 = ports[8:6];
    bus2.port_3 = ports[11:9]; bus2.port_4 = ports[14:12];
    bus2.tail = tail; bus2.credit_ret = cr;
  endtask

  task automatic check_out();
    vec_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard (vec %0d): got empty queue want entry", vec_n);
      return;
    end
    e = sb_q.pop_front();
    if (e.d2) begin
      chk("grt2",  8'(bus2.grt),      8'(e.grt));
      chk("sel2",  8'(bus2.sel),      8'(e.sel));
      chk("busy2", 8'(bus2.busy),     8'(e.busy));
      chk("cred2", 8'(bus2.credits),  8'(e.cred));
      chk("err2",  8'(bus2.cred_err), 8'(e.err));
    end else begin
      chk("grt",  8'(bus.grt),      8'(e.grt));
      chk("sel",  8'(bus.sel),      8'(e.sel));
      chk("busy", 8'(bus.busy),     8'(e.busy));
      chk("cred", 8'(bus.credits),  8'(e.cred));
      chk("err",  8'(bus.cred_err), 8'(e.err));
    end
  endtask

  // Called at posedge+1: apply one cycle of inputs, compare mid-cycle
  task automatic run_vec(input vec_t v);
    drive(v.req, v.ports, v.tail, v.cr);
    sb_q.push_back(v);
    @(negedge clk);
    check_out();
    vec_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'd0, 15'd0, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_grt",   8'(bus.grt),      8'h00);
    chk("rst_sel",   8'(bus.sel),      8'h00);
    chk("rst_busy",  8'(bus.busy),     8'h00);
    chk("rst_cred",  8'(bus.credits),  8'h04);
    chk("rst_err",   8'(bus.cred_err), 8'h00);
    chk("rst_cred2", 8'(bus2.credits), 8'h02);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] oh;
    for (int p = 0; p < 6; p++) begin
      oh = 5'b00001 << (p % 5);
      tbl[3*p]   = mk(5'h1f, 15'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0);
      tbl[3*p+1] = mk(5'h1f, 15'd0, 5'd0, 1'b1, 1'b0, oh,   oh,   1'b1, 3'd4, 1'b0);
      tbl[3*p+2] = mk(5'h1f, 15'd0, oh,   1'b1, 1'b0, oh,   oh,   1'b1, 3'd4, 1'b0);
    end

    // Round-robin over all five inputs with 2-flit packets
    do_reset();
    for (int i = 0; i < 18; i++) run_vec(tbl[i]);

    // Wormhole hold, owner stall, next-owner selection and wrap
    do_reset();
    run_vec(mk(5'b00100, 15'd0, 5'd0,     1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));
    run_vec(mk(5'b00100, 15'd0, 5'd0,     1'b1, 1'b0, 5'b00100, 5'b00100, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b01110, 15'd0, 5'd0,     1'b1, 1'b0, 5'b00100, 5'b00100, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b01010, 15'd0, 5'd0,     1'b0, 1'b0, 5'd0,     5'b00100, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b01110, 15'd0, 5'b00100, 1'b1, 1'b0, 5'b00100, 5'b00100, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b01010, 15'd0, 5'd0,     1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));
    run_vec(mk(5'b01010, 15'd0, 5'b01000, 1'b1, 1'b0, 5'b01000, 5'b01000, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b00010, 15'd0, 5'd0,     1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));
    run_vec(mk(5'b00010, 15'd0, 5'b00010, 1'b1, 1'b0, 5'b00010, 5'b00010, 1'b1, 3'd4, 1'b0));
    run_vec(mk(5'b00000, 15'd0, 5'd0,     1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));

    // Input 4 addressed to another port is never eligible
    do_reset();
    for (int i = 0; i < 4; i++)
      run_vec(mk(5'b10000, 15'd1 << 12, 5'b10000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0));

    // Asynchronous reset while locked to input 3
    do_reset();
    run_vec(mk(5'b01000, 15'd0, 5'd0, 1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));
    run_vec(mk(5'b01000, 15'd0, 5'd0, 1'b0, 1'b0, 5'b01000, 5'b01000, 1'b1, 3'd4, 1'b0));
    chk("pre_rst_cred", 8'(bus.credits), 8'h03);
    chk("pre_rst_busy", 8'(bus.busy),    8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grt",  8'(bus.grt),     8'h00);
    chk("arst_sel",  8'(bus.sel),     8'h00);
    chk("arst_busy", 8'(bus.busy),    8'h00);
    chk("arst_cred", 8'(bus.credits), 8'h04);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(mk(5'h1f, 15'd0, 5'd0, 1'b0, 1'b0, 5'd0,     5'd0,     1'b0, 3'd4, 1'b0));
    run_vec(mk(5'h1f, 15'd0, 5'd0, 1'b0, 1'b0, 5'b00001, 5'b00001, 1'b1, 3'd4, 1'b0));

    // Credit exhaustion, single return, simultaneous fire/return, overflow
    do_reset();
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 3'd2, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 3'd2, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 3'd1, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 3'd1, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0));
    run_vec(mk(5'b00001, 15'd0, 5'd1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 3'd1, 1'b0));
    run_vec(mk(5'b00000, 15'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0));
    run_vec(mk(5'b00000, 15'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 3'd2, 1'b0));
    run_vec(mk(5'b00000, 15'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 3'd2, 1'b1));
    run_vec(mk(5'b00000, 15'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 3'd2, 1'b1));

    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
